k16_bus_arbiter: RTL and testbench

Single-port memory arbiter between the K16Cpu bus and the VGA line-fetch engine. Owns the one synchronous RAM, grants the CPU by default, and steals cycles for video bursts by asserting `hold` to the CPU. Sits directly downstream of K16Cpu: CPU `address`/`data_out`/`write` enter here, and CPU `data_in` and `hold` leave here.

---
 rtl/k16_bus_pkg.sv | 13 +
 rtl/k16_bus_arbiter.sv | 94 +++++++++
 tb/tb_k16_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/k16_bus_pkg.sv
// Shared types for the K16 memory arbiter: bus widths and arbiter state encoding.
package k16_bus_pkg;

    localparam int K16_ADDR_W = 16;
    localparam int K16_DATA_W = 16;

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_VID = 2'd1,
        S_REL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/k16_bus_arbiter.sv
// Single-port RAM arbiter: CPU owns the bus by default, video steals bursts of up to BURST_MAX beats.
// Latency: vid_ack 1 cycle after vid_req (CPU idle), vid_valid 1 cycle after vid_ack; CPU stalled via registered cpu_hold.
// Backpressure: CPU is never preempted while cpu_busy; one guaranteed CPU cycle follows every burst.
module k16_bus_arbiter
    import k16_bus_pkg::*;
#(
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [K16_ADDR_W-1:0] cpu_address,
    input  logic [K16_DATA_W-1:0] cpu_data_out,
    input  logic                  cpu_write,
    input  logic                  cpu_busy,
    output logic                  cpu_hold,
    output logic [K16_DATA_W-1:0] cpu_data_in,
    input  logic                  vid_req,
    input  logic [K16_ADDR_W-1:0] vid_address,
    output logic                  vid_ack,
    output logic                  vid_valid,
    output logic [K16_DATA_W-1:0] vid_data,
    output logic [K16_ADDR_W-1:0] mem_address,
    output logic [K16_DATA_W-1:0] mem_data_out,
    output logic                  mem_write,
    input  logic [K16_DATA_W-1:0] mem_data_in
);

    localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);

    arb_state_t state;
    arb_state_t state_nxt;
    logic [7:0] beat_cnt;
    logic [8:0] beat_inc;
    logic       fair;

    // Both consumers see the RAM read port directly; ownership is implied by timing.
    assign cpu_data_in  = mem_data_in;
    assign vid_data     = mem_data_in;
    assign mem_data_out = cpu_data_out;
    assign beat_inc     = {1'b0, beat_cnt} + 9'd1;

    always_comb begin
        state_nxt   = state;
        mem_address = cpu_address;
        mem_write   = 1'b0;
        vid_ack     = 1'b0;
        case (state)
            S_CPU: begin
                mem_write = cpu_write;
                if (vid_req && !cpu_busy && !fair) begin
                    state_nxt = S_VID;
                end
            end
            S_VID: begin
                mem_address = vid_address;
                vid_ack     = 1'b1;
                if (!(vid_req && (beat_inc < BURST_LIM))) begin
                    state_nxt = S_REL;
                end
            end
            // Release drives the CPU address early so its re-presented read is ready on return.
            S_REL: begin
                state_nxt = S_CPU;
            end
            default: begin
                state_nxt = S_CPU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CPU;
            cpu_hold  <= 1'b0;
            vid_valid <= 1'b0;
            beat_cnt  <= 8'd0;
            fair      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_hold  <= (state_nxt != S_CPU);
            vid_valid <= vid_ack;
            case (state)
                S_VID: beat_cnt <= beat_inc[7:0];
                S_REL: begin
                    beat_cnt <= 8'd0;
                    fair     <= 1'b1;
                end
                S_CPU:   fair <= 1'b0;
                default: beat_cnt <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_k16_bus_arbiter.sv
// Bench for k16_bus_arbiter: directed vector table, hand-built burst/write/reset sequences,
// then randomized traffic checked against a cycle-level reference model of the arbitration rules.
module tb_k16_bus_arbiter;
    import k16_bus_pkg::*;

    localparam int BM = 8;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_address, cpu_data_out, vid_address, mem_data_in;
    logic        cpu_write, cpu_busy, vid_req;
    logic        cpu_hold, vid_ack, vid_valid, mem_write;
    logic [15:0] cpu_data_in, vid_data, mem_address, mem_data_out;

    int n_chk  = 0;
    int n_fail = 0;

    k16_bus_arbiter #(.BURST_MAX(BM)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_write    (cpu_write),
        .cpu_busy     (cpu_busy),
        .cpu_hold     (cpu_hold),
        .cpu_data_in  (cpu_data_in),
        .vid_req      (vid_req),
        .vid_address  (vid_address),
        .vid_ack      (vid_ack),
        .vid_valid    (vid_valid),
        .vid_data     (vid_data),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: preset contents from a pattern, written words tracked sparsely.
    logic [15:0] bram_wr [int];
    logic [15:0] ref_wr  [int];

    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a == 16'h8000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    function logic [15:0] bram_rd(input logic [15:0] a);
        return bram_wr.exists(int'(a)) ? bram_wr[int'(a)] : pat(a);
    endfunction

    function logic [15:0] ref_rd(input logic [15:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : pat(a);
    endfunction

    always @(posedge clk) begin
        mem_data_in <= bram_rd(mem_address);
        if (mem_write === 1'b1) bram_wr[int'(mem_address)] = mem_data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus this cycle and how many beats the burst has used.
    bit          m_known, m_burst, m_rel, m_cool, m_hold, m_valid, m_rd_ok;
    int          m_beats;
    logic [15:0] m_rd;

    task automatic model_check();
        logic [15:0] e_maddr;
        logic        e_mwr;
        e_maddr = m_burst ? vid_address : cpu_address;
        e_mwr   = (!m_burst && !m_rel) ? cpu_write : 1'b0;
        check("m_hold", cpu_hold, m_hold);
        check("m_ack", vid_ack, m_burst);
        check("m_valid", vid_valid, m_valid);
        check("m_mem_write", mem_write, e_mwr);
        check("m_mem_address", mem_address, e_maddr);
        check("m_mem_data_out", mem_data_out, cpu_data_out);
        if (m_rd_ok) check("m_cpu_data_in", cpu_data_in, m_rd);
        if (m_rd_ok && m_valid) check("m_vid_data", vid_data, m_rd);
    endtask

    task automatic model_step();
        logic [15:0] e_maddr;
        logic        e_mwr;
        int          done;
        e_maddr = m_burst ? vid_address : cpu_address;
        e_mwr   = (!m_burst && !m_rel) ? cpu_write : 1'b0;
        m_rd    = ref_rd(e_maddr);
        m_rd_ok = 1'b1;
        if (m_known && e_mwr) ref_wr[int'(e_maddr)] = cpu_data_out;
        if (reset) begin
            m_known = 1; m_burst = 0; m_rel = 0; m_cool = 0;
            m_beats = 0; m_hold = 0; m_valid = 0;
        end else begin
            m_valid = m_burst;
            if (m_burst) begin
                done = m_beats + 1;
                if (vid_req && done < BM) m_beats = done;
                else begin m_burst = 0; m_rel = 1; m_beats = 0; end
            end else if (m_rel) begin
                m_rel = 0; m_cool = 1;
            end else begin
                if (vid_req && !cpu_busy && !m_cool) begin m_burst = 1; m_beats = 0; end
                m_cool = 0;
            end
            m_hold = m_burst || m_rel;
        end
    endtask

    typedef struct {
        logic rst, busy, vreq;
        logic [15:0] vaddr;
        logic cwr;
        logic [15:0] caddr, cdat;
        logic chk, e_hold, e_ack, e_valid, e_mwr;
        logic [15:0] e_maddr;
        logic rdk;
        logic [15:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic rst, busy, vreq, input logic [15:0] vaddr,
                                input logic cwr, input logic [15:0] caddr, cdat,
                                input logic chk, eh, ea, ev, ew, input logic [15:0] ema,
                                input logic rdk, input logic [15:0] erd);
        vec_t v;
        v.rst = rst; v.busy = busy; v.vreq = vreq; v.vaddr = vaddr; v.cwr = cwr;
        v.caddr = caddr; v.cdat = cdat; v.chk = chk; v.e_hold = eh; v.e_ack = ea;
        v.e_valid = ev; v.e_mwr = ew; v.e_maddr = ema; v.rdk = rdk; v.e_rd = erd;
        return v;
    endfunction

    logic        obs_hold, obs_ack, obs_valid, obs_mwr;
    logic [15:0] obs_maddr, obs_rd, obs_vdata;

    task automatic apply(input vec_t v);
        reset = v.rst; cpu_busy = v.busy; vid_req = v.vreq; vid_address = v.vaddr;
        cpu_write = v.cwr; cpu_address = v.caddr; cpu_data_out = v.cdat;
        @(negedge clk);
        obs_hold = cpu_hold; obs_ack = vid_ack; obs_valid = vid_valid; obs_mwr = mem_write;
        obs_maddr = mem_address; obs_rd = cpu_data_in; obs_vdata = vid_data;
        if (m_known) model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t idle(input logic [15:0] caddr);
        return mk(0, 0, 0, 16'h0, 0, caddr, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    endfunction

    vec_t tbl[$];
    logic cap_hold [0:19];
    logic cap_ack  [0:19];

    initial begin
        m_known = 0; m_burst = 0; m_rel = 0; m_cool = 0; m_hold = 0; m_valid = 0;
        m_rd_ok = 0; m_beats = 0; m_rd = 16'h0;

        //          rst bsy vrq vaddr     cwr caddr     cdat  chk hld ack vld mwr maddr     rdk rd
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0001, 16'h0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 1, 16'h5A5B));
        tbl.push_back(mk(0, 0, 1, 16'h8000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 16'h0001, 16'h0, 1, 1, 1, 0, 0, 16'h8000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 16'h0001, 16'h0, 1, 1, 0, 1, 0, 16'h0001, 1, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0, 1, 0, 0, 0, 0, 16'h0001, 0, 16'h0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 1, 16'h9000, 0, 16'h0002, 16'h0, 1, 0, 0, 0, 0, 16'h0002, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 16'h9000, 0, 16'h0002, 16'h0, 1, 0, 0, 0, 0, 16'h0002, 0, 16'h0));
        tbl.push_back(mk(0, 0, 1, 16'h9000, 0, 16'h0002, 16'h0, 1, 1, 1, 0, 0, 16'h9000, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h9001, 0, 16'h0002, 16'h0, 1, 1, 1, 1, 0, 16'h9001, 1, 16'hCA5A));
        tbl.push_back(mk(0, 0, 0, 16'h9001, 0, 16'h0002, 16'h0, 1, 1, 0, 1, 0, 16'h0002, 1, 16'hCA5B));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0002, 16'h0, 1, 0, 0, 0, 0, 16'h0002, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0002, 16'h0, 1, 0, 0, 0, 0, 16'h0002, 0, 16'h0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_hold", i), obs_hold, tbl[i].e_hold);
                check($sformatf("vec%0d_ack", i), obs_ack, tbl[i].e_ack);
                check($sformatf("vec%0d_valid", i), obs_valid, tbl[i].e_valid);
                check($sformatf("vec%0d_mem_write", i), obs_mwr, tbl[i].e_mwr);
                check($sformatf("vec%0d_mem_address", i), obs_maddr, tbl[i].e_maddr);
                if (tbl[i].rdk) check($sformatf("vec%0d_cpu_data_in", i), obs_rd, tbl[i].e_rd);
                if (tbl[i].rdk && tbl[i].e_valid)
                    check($sformatf("vec%0d_vid_data", i), obs_vdata, tbl[i].e_rd);
            end
        end

        // Capped burst: request held for 20 cycles; bursts repeat every BM+3 cycles
        // (decision, BM beats, release, one fairness cycle).
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, 0, 1, 16'h4000 + 16'(i), 0, 16'h0003, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
            cap_hold[i] = obs_hold;
            cap_ack[i]  = obs_ack;
        end
        begin
            int nack;
            int ph;
            nack = 0;
            for (int i = 0; i < 20; i++) begin
                ph = i % (BM + 3);
                check($sformatf("cap_hold_c%0d", i), cap_hold[i], (ph >= 1 && ph <= BM + 1));
                check($sformatf("cap_ack_c%0d", i), cap_ack[i], (ph >= 1 && ph <= BM));
                if (cap_ack[i]) nack++;
            end
            check("cap_ack_count", nack, 2 * BM);
        end
        for (int i = 0; i < 3; i++) apply(idle(16'h0003));

        // Write protection: the CPU's pending write must wait out the burst.
        apply(mk(0, 0, 1, 16'h5000, 0, 16'h0020, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        check("wp_pre_hold", obs_hold, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            apply(mk(0, 0, (i < 4), 16'h5000 + 16'(i), 1, 16'h0010, 16'hBEEF,
                     0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
            check($sformatf("wp_hold_c%0d", i), obs_hold, 1'b1);
            check($sformatf("wp_mem_write_c%0d", i), obs_mwr, 1'b0);
        end
        apply(mk(0, 0, 0, 16'h0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        check("wp_release_hold", obs_hold, 1'b0);
        check("wp_release_write", obs_mwr, 1'b1);
        check("wp_release_addr", obs_maddr, 16'h0010);
        apply(idle(16'h0010));
        check("wp_ram_word", bram_rd(16'h0010), 16'hBEEF);
        apply(idle(16'h0010));
        check("wp_readback", obs_rd, 16'hBEEF);

        // Reset in the third beat of a burst.
        apply(mk(0, 0, 1, 16'h6000, 0, 16'h0030, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        apply(mk(0, 0, 1, 16'h6000, 0, 16'h0030, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        apply(mk(0, 0, 1, 16'h6001, 0, 16'h0030, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        apply(mk(1, 0, 1, 16'h6002, 0, 16'h0030, 16'h0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0));
        check("rst_in_burst_ack", obs_ack, 1'b1);
        apply(idle(16'h0030));
        check("rst_hold", obs_hold, 1'b0);
        check("rst_ack", obs_ack, 1'b0);
        check("rst_valid", obs_valid, 1'b0);
        check("rst_mem_address", obs_maddr, 16'h0030);
        check("rst_state", 32'(dut.state), 32'(S_CPU));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v = idle(16'($urandom_range(0, 63)));
            v.rst   = ($urandom_range(0, 199) == 0);
            v.busy  = ($urandom_range(0, 3) == 0);
            v.vreq  = ($urandom_range(0, 3) != 0);
            v.vaddr = 16'($urandom_range(0, 63));
            v.cwr   = $urandom_range(0, 1) != 0;
            v.cdat  = 16'($urandom);
            apply(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
